// File: rtl/cache_refill_arbiter.sv
// Two-port cache refill arbiter: grants one requester a BLOCKS-word memory read burst and
// steers returned words to it. Define CACHE_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0).
module cache_refill_arbiter #(
    parameter int TAG_WIDTH   = 3,
    parameter int INDEX_WIDTH = 5,
    parameter int BLOCK_WIDTH = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset,
    input  logic                                     i_req0,
    input  logic [TAG_WIDTH-1:0]                     i_tag0,
    input  logic [INDEX_WIDTH-1:0]                   i_index0,
    output logic                                     o_gnt0,
    output logic                                     o_wr0,
    input  logic                                     i_req1,
    input  logic [TAG_WIDTH-1:0]                     i_tag1,
    input  logic [INDEX_WIDTH-1:0]                   i_index1,
    output logic                                     o_gnt1,
    output logic                                     o_wr1,
    output logic [BLOCK_WIDTH-1:0]                   o_block,
    output logic [DATA_WIDTH-1:0]                    o_data,
    output logic                                     o_mem_rd,
    output logic [TAG_WIDTH+INDEX_WIDTH+BLOCK_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]                    i_mem_data,
    input  logic                                     i_mem_ready,
    output logic                                     o_busy
);

    localparam logic [BLOCK_WIDTH-1:0] LAST_BLOCK = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic                     owner, owner_next;
    logic [TAG_WIDTH-1:0]     tag_q, tag_next;
    logic [INDEX_WIDTH-1:0]   index_q, index_next;
    logic [BLOCK_WIDTH-1:0]   block_q, block_next;
    logic                     winner;

`ifdef CACHE_ARBITER_FIXED_PRIO_EN
    assign winner = ~i_req0;
`else
    logic rr_q, rr_next;

    // On a tie the rr pointer decides; it names the loser of the previous burst.
    assign winner = (i_req0 && i_req1) ? rr_q : i_req1;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            tag_q   <= '0;
            index_q <= '0;
            block_q <= '0;
`ifndef CACHE_ARBITER_FIXED_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            tag_q   <= tag_next;
            index_q <= index_next;
            block_q <= block_next;
`ifndef CACHE_ARBITER_FIXED_PRIO_EN
            rr_q    <= rr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        tag_next   = tag_q;
        index_next = index_q;
        block_next = block_q;
`ifndef CACHE_ARBITER_FIXED_PRIO_EN
        rr_next    = rr_q;
`endif
        o_gnt0     = 1'b0;
        o_gnt1     = 1'b0;
        o_wr0      = 1'b0;
        o_wr1      = 1'b0;
        o_block    = '0;
        o_data     = '0;
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        o_busy     = (state != IDLE);

        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    owner_next = winner;
                    tag_next   = winner ? i_tag1 : i_tag0;
                    index_next = winner ? i_index1 : i_index0;
                    block_next = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                o_gnt0     = ~owner;
                o_gnt1     = owner;
                o_mem_rd   = 1'b1;
                o_mem_addr = {tag_q, index_q, block_q};
                // A stalled cycle simply repeats the same address.
                if (i_mem_ready) begin
                    o_wr0      = ~owner;
                    o_wr1      = owner;
                    o_data     = i_mem_data;
                    o_block    = block_q;
                    block_next = block_q + 1'b1;
                    if (block_q == LAST_BLOCK) begin
                        state_next = RELEASE;
                    end
                end
            end
            RELEASE: begin
`ifndef CACHE_ARBITER_FIXED_PRIO_EN
                rr_next    = ~owner;
`endif
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
